// File: rtl/fsm_pkg.sv
// Shared types and constants for the fsm detector sequencer and its tooling.
// Holds the controller state encoding, the default detector latency and the xin idle level.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int   Y_LAT_DEFAULT = 1;
  localparam logic XIN_IDLE      = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Count updates one cycle after inc; holds at all-ones; no backpressure.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fsm_sequencer.sv
// Serialises a parallel pattern MSB-first into the fsm detector and collects its responses.
// Accept to done is WIDTH+Y_LAT+1 cycles; in_ready is low while busy, so the requester holds pattern.
module fsm_sequencer
  import fsm_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int Y_LAT = Y_LAT_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic             abort,
  output logic             xin_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] match_mask,
  output logic [CNT_W-1:0] match_count
);

  localparam int STEP_W = $clog2(WIDTH + Y_LAT + 1);
  localparam logic [STEP_W-1:0] LAST_SHIFT = STEP_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(WIDTH + Y_LAT - 1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic              xin_q, xin_d;
  logic              done_q, done_d;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_inc;

  assign in_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy     = (state_q == SHIFT) || (state_q == FLUSH);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sh_d    = sh_q;
    mask_d  = mask_q;
    xin_d   = XIN_IDLE;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = SHIFT;
          step_d  = '0;
          sh_d    = pattern << 1;
          xin_d   = pattern[WIDTH-1];
          mask_d  = '0;
          cnt_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT, FLUSH: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else begin
          // The response for bit i arrives Y_LAT steps after it was driven.
          for (int i = 0; i < WIDTH; i++) begin
            if (step_q == STEP_W'(i + Y_LAT)) begin
              mask_d[i] = y_in;
              cnt_inc   = y_in;
            end
          end
          step_d = step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (step_q == LAST_SHIFT) begin
            state_d = FLUSH;
          end else begin
            xin_d = sh_q[WIDTH-1];
            sh_d  = sh_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      sh_q    <= '0;
      mask_q  <= '0;
      xin_q   <= XIN_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sh_q    <= sh_d;
      mask_q  <= mask_d;
      xin_q   <= xin_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (match_count)
  );

  assign xin_out    = xin_q;
  assign done       = done_q;
  assign match_mask = mask_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: directed and randomised jobs against a job-level model.
module tb_fsm_sequencer;

  localparam int W  = 9;
  localparam int YL = 1;
  localparam int CW = 4;
  localparam int N  = W + YL;
  localparam int NY = N + 3;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pattern;
  logic          abort;
  logic          xin_out;
  logic          y_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  match_mask;
  logic [CW-1:0] match_count;

  int vectors;
  int miscompares;

  logic [NY-1:0] obs_xin;
  logic [NY-1:0] obs_busy;
  int            obs_done_cyc;
  int            obs_done_cnt;
  logic [W-1:0]  obs_mask;
  logic [W-1:0]  obs_mask_end;
  logic [CW-1:0] obs_cnt;

  fsm_sequencer #(
    .WIDTH(W),
    .Y_LAT(YL),
    .CNT_W(CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pattern    (pattern),
    .abort      (abort),
    .xin_out    (xin_out),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .match_mask (match_mask),
    .match_count(match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Offers one job from idle and records what the DUT shows in cycles 1..N+2 after accept.
  task automatic drive_job(input logic [W-1:0] p, input logic [NY-1:0] yv, input logic ab_acc);
    @(posedge clock); #1;
    in_valid = 1'b1; pattern = p; y_in = 1'b0; abort = ab_acc;
    @(posedge clock); #1;
    in_valid = 1'b0; abort = 1'b0; pattern = W'($urandom);
    obs_xin = '0; obs_busy = '0; obs_done_cyc = 0; obs_done_cnt = 0;
    obs_mask = '0; obs_cnt = '0;
    for (int j = 1; j <= N + 2; j++) begin
      y_in = yv[j];
      @(negedge clock);
      obs_xin[j]  = xin_out;
      obs_busy[j] = busy;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) begin
          obs_done_cyc = j;
          obs_mask = match_mask;
          obs_cnt  = match_count;
        end
      end
      obs_mask_end = match_mask;
      @(posedge clock); #1;
    end
    y_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; pattern = '0; abort = 1'b0; y_in = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      vectors++;
      if ({in_ready, busy, xin_out, done, match_count} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got rdy=%b busy=%b xin=%b done=%b cnt=%0d want rdy=1 busy=0 xin=0 done=0 cnt=0",
                 c, in_ready, busy, xin_out, done, match_count);
      end
    end
  endtask

  // One complete job checked against the serial/response model.
  task automatic test_job(input string name, input logic [W-1:0] p, input logic [NY-1:0] yv,
                          input logic ab_acc);
    logic [W-1:0] exp_mask;
    int           ones;
    int           exp_cnt;
    logic         exp_x;
    drive_job(p, yv, ab_acc);
    ones = 0;
    for (int i = 0; i < W; i++) begin
      exp_mask[i] = yv[i + 1 + YL];
      if (exp_mask[i]) ones++;
    end
    exp_cnt = (ones > (1 << CW) - 1) ? (1 << CW) - 1 : ones;
    for (int j = 1; j <= N + 2; j++) begin
      exp_x = (j <= W) ? p[W - j] : 1'b0;
      vectors++;
      if (obs_xin[j] !== exp_x) begin
        miscompares++;
        $display("FAIL %s xin cycle %0d: got %b want %b", name, j, obs_xin[j], exp_x);
      end
      vectors++;
      if (obs_busy[j] !== (j <= N)) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, j, obs_busy[j], (j <= N));
      end
    end
    vectors++;
    if (obs_done_cyc !== N + 1 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s done: got cycle %0d x%0d want cycle %0d x1", name, obs_done_cyc, obs_done_cnt, N + 1);
    end
    vectors++;
    if (obs_mask !== exp_mask) begin
      miscompares++;
      $display("FAIL %s mask: got %h want %h", name, obs_mask, exp_mask);
    end
    vectors++;
    if (obs_cnt !== CW'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s count: got %0d want %0d", name, obs_cnt, exp_cnt);
    end
    vectors++;
    if (obs_mask_end !== exp_mask) begin
      miscompares++;
      $display("FAIL %s mask_hold: got %h want %h", name, obs_mask_end, exp_mask);
    end
  endtask

  task automatic test_random(input int jobs);
    logic [NY-1:0] yv;
    for (int k = 0; k < jobs; k++) begin
      yv = '0;
      for (int j = 1; j <= N; j++) yv[j] = 1'($urandom_range(0, 1));
      test_job("random", W'($urandom), yv, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    @(posedge clock); #1;
    in_valid = 1'b1; pattern = 9'h1FF; y_in = 1'b0;
    @(posedge clock); #1;
    pattern = 9'h000;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clock);
      if (done) done_cyc.push_back(j);
      if (j <= W) begin
        vectors++;
        if (xin_out !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b xin cycle %0d: got %b want 1", j, xin_out);
        end
      end
      if (j == N + 2) begin
        vectors++;
        if ({busy, in_ready, xin_out} !== 3'b100) begin
          miscompares++;
          $display("FAIL b2b second_start: got busy=%b rdy=%b xin=%b want busy=1 rdy=0 xin=0", busy, in_ready, xin_out);
        end
      end
      @(posedge clock); #1;
      if (j == N + 1) in_valid = 1'b0;
    end
    vectors++;
    if (done_cyc.size() != 2) begin
      miscompares++;
      $display("FAIL b2b done_count: got %0d want 2", done_cyc.size());
    end else begin
      vectors++;
      if (done_cyc[0] != N + 1 || done_cyc[1] - done_cyc[0] != N + 1) begin
        miscompares++;
        $display("FAIL b2b done_spacing: got %0d,%0d want %0d,%0d", done_cyc[0], done_cyc[1], N + 1, 2 * (N + 1));
      end
    end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; pattern = W'($urandom); y_in = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      abort = (j == 5);
      @(negedge clock);
      if (done) dones++;
      vectors++;
      if (j <= 5 && busy !== 1'b1) begin
        miscompares++;
        $display("FAIL abort busy cycle %0d: got %b want 1", j, busy);
      end else if (j >= 6 && {in_ready, busy, xin_out} !== 3'b100) begin
        miscompares++;
        $display("FAIL abort idle cycle %0d: got rdy=%b busy=%b xin=%b want rdy=1 busy=0 xin=0", j, in_ready, busy, xin_out);
      end
      @(posedge clock); #1;
    end
    abort = 1'b0; y_in = 1'b0;
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort no_done: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    logic [NY-1:0] yv;
    @(posedge clock); #1;
    in_valid = 1'b1; pattern = 9'h1FF; y_in = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #2;
    vectors++;
    if ({in_ready, busy, xin_out, done, match_mask, match_count} !== {4'b1000, W'(0), CW'(0)}) begin
      miscompares++;
      $display("FAIL reset_mid clear: got rdy=%b busy=%b xin=%b done=%b mask=%h cnt=%0d want 1,0,0,0,000,0",
               in_ready, busy, xin_out, done, match_mask, match_count);
    end
    y_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    yv = '0;
    yv[3] = 1'b1; yv[7] = 1'b1;
    test_job("after_reset", 9'b101100101, yv, 1'b0);
  endtask

  initial begin
    logic [NY-1:0] yv;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_job("zeros", 9'b011110011, '0, 1'b0);
    yv = '0;
    for (int j = 1; j <= N; j++) yv[j] = 1'b1;
    test_job("ones", 9'b011110011, yv, 1'b0);
    yv = '0;
    yv[5] = 1'b1; yv[10] = 1'b1;
    test_job("pulses", 9'b011110011, yv, 1'b0);
    test_random(20);
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
